fetch_pc_gen: RTL and testbench

Fetch-stage PC generator that sits directly upstream of the gshare branch predictor. It drives the word-addressed fetch PC into the predictor and instruction memory, and combines the predictor's same-cycle taken/not-taken bit with an internal branch target buffer (BTB) to choose the next PC. It keeps a small in-order queue of outstanding predictions, compares each against the execute stage's resolution, and performs redirect and flush on a mispredict.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_pred_queue.sv | 61 ++++++
 rtl/fetch_pc_gen.sv | 131 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package fetch_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] RESET_PC = '0;

   // One outstanding prediction waiting for its execute-stage resolution.
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            taken;
      logic [PC_W-1:0] target;
   } pq_entry_t;

   // BTB entry. The tag field is PC_W wide and holds pc >> idx_w, so the
   // type stays valid for any BTB index width.
   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] tag;
      logic [PC_W-1:0] target;
   } btb_entry_t;

   // Tag of a PC for a BTB indexed by its low idx_w bits.
   function automatic logic [PC_W-1:0] btb_tag_of(input logic [PC_W-1:0] pc_in,
                                                  input int             idx_w);
      return pc_in >> idx_w;
   endfunction

endpackage

// File: rtl/fetch_pred_queue.sv
// In-order queue of outstanding branch predictions. Flush beats push.
// A push is accepted when full only if a pop happens in the same cycle.
module fetch_pred_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  pq_entry_t push_data,
   input  logic      pop,
   input  logic      flush,
   output logic      full,
   output logic      empty,
   output pq_entry_t head
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   pq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the queue and wins over push.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; validity comes from
      // the reset pointers/count, which keeps the array a plain RAM.
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: registered fetch PC, BTB-qualified next-PC
// selection, prediction queue, and mispredict redirect/flush.
// PC width comes from fetch_pkg::PC_W.
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int              BTB_IDX_W = 6,
   parameter int              PQ_DEPTH  = 4,
   parameter logic [PC_W-1:0] RESET_PC  = fetch_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            pred_taken,
   input  logic            resolve_valid,
   input  logic            resolve_taken,
   input  logic [PC_W-1:0] resolve_target,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            fetch_fire,
   output logic            fetch_pred_taken,
   output logic            mispredict,
   output logic            proto_err
);

   localparam int BTB_ENTRIES = 1 << BTB_IDX_W;

   // BTB storage: valid bits are reset, tag/target arrays are plain RAM.
   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [PC_W-1:0]        btb_tag    [BTB_ENTRIES];
   logic [PC_W-1:0]        btb_target [BTB_ENTRIES];

   logic [BTB_IDX_W-1:0] rd_idx;
   logic [BTB_IDX_W-1:0] wr_idx;
   btb_entry_t           btb_rd;
   btb_entry_t           btb_wr;
   logic                 btb_hit;
   logic                 btb_we;

   pq_entry_t       pq_head;
   pq_entry_t       pq_push_data;
   logic            pq_full;
   logic            pq_empty;
   logic            pq_push;
   logic            pq_pop;

   logic            mismatch;
   logic [PC_W-1:0] correct_pc;
   logic [PC_W-1:0] next_pc;

   // Asynchronous BTB read for the current fetch PC.
   assign rd_idx  = pc[BTB_IDX_W-1:0];
   assign btb_rd  = '{valid:  btb_valid[rd_idx],
                      tag:    btb_tag[rd_idx],
                      target: btb_target[rd_idx]};
   assign btb_hit = btb_rd.valid && (btb_rd.tag == btb_tag_of(pc, BTB_IDX_W));

   assign fetch_fire       = fetch_valid & ~stall & ~pq_full;
   assign fetch_pred_taken = pred_taken & btb_hit;

   // Resolution against the oldest outstanding prediction.
   assign pq_pop     = resolve_valid & ~pq_empty;
   assign correct_pc = resolve_taken ? resolve_target : pq_head.pc + 1'b1;
   assign mismatch   = pq_pop &
                       ((pq_head.taken != resolve_taken) ||
                        (pq_head.taken && resolve_taken && (pq_head.target != resolve_target)));

   // A redirect discards whatever was fetched in the same cycle.
   assign pq_push      = fetch_fire & ~mismatch;
   assign pq_push_data = '{pc: pc, taken: fetch_pred_taken, target: btb_rd.target};

   // Taken resolutions train the BTB entry of the resolved fetch PC.
   assign btb_we = pq_pop & resolve_taken;
   assign wr_idx = pq_head.pc[BTB_IDX_W-1:0];
   assign btb_wr = '{valid: 1'b1, tag: btb_tag_of(pq_head.pc, BTB_IDX_W), target: resolve_target};

   fetch_pred_queue #(
      .DEPTH (PQ_DEPTH)
   ) u_pred_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (pq_push),
      .push_data (pq_push_data),
      .pop       (pq_pop),
      .flush     (mismatch),
      .full      (pq_full),
      .empty     (pq_empty),
      .head      (pq_head)
   );

   // Next-PC selection: redirect, hold, predicted target, sequential.
   always_comb begin
      // NOTE: next_pc gets a default before any branch so no path can leave
      // it unassigned and infer a latch.
      next_pc = pc;
      if (mismatch)              next_pc = correct_pc;
      else if (!fetch_fire)      next_pc = pc;
      else if (fetch_pred_taken) next_pc = btb_rd.target;
      else                       next_pc = pc + 1'b1;
   end

   // Fetch PC, valid, mispredict pulse and sticky protocol error.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         fetch_valid <= 1'b0;
         mispredict  <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         pc          <= next_pc;
         fetch_valid <= 1'b1;
         mispredict  <= mismatch;
         if (resolve_valid && pq_empty) proto_err <= 1'b1;
      end
   end

   // BTB valid bits clear on reset and set on training writes.
   always_ff @(posedge clk) begin
      if (rst)         btb_valid         <= '0;
      else if (btb_we) btb_valid[wr_idx] <= 1'b1;
   end

   // BTB tag/target RAM; a write lands after the edge, so same-cycle reads see old data.
   always_ff @(posedge clk) begin
      if (btb_we && !rst) begin
         btb_tag[wr_idx]    <= btb_wr.tag;
         btb_target[wr_idx] <= btb_wr.target;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vector table plus a
// randomized run against a queue-based reference model.
module tb_fetch_pc_gen;
   import fetch_pkg::*;

   localparam int IDX_W   = 6;
   localparam int DEPTH   = 4;
   localparam int ENTRIES = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic            pred_taken;
   logic            resolve_valid;
   logic            resolve_taken;
   logic [PC_W-1:0] resolve_target;
   logic [PC_W-1:0] pc;
   logic            fetch_valid;
   logic            fetch_fire;
   logic            fetch_pred_taken;
   logic            mispredict;
   logic            proto_err;

   always #5 clk = ~clk;

   fetch_pc_gen #(
      .BTB_IDX_W (IDX_W),
      .PQ_DEPTH  (DEPTH),
      .RESET_PC  ('0)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .pred_taken       (pred_taken),
      .resolve_valid    (resolve_valid),
      .resolve_taken    (resolve_taken),
      .resolve_target   (resolve_target),
      .pc               (pc),
      .fetch_valid      (fetch_valid),
      .fetch_fire       (fetch_fire),
      .fetch_pred_taken (fetch_pred_taken),
      .mispredict       (mispredict),
      .proto_err        (proto_err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      bit          taken;
      logic [31:0] target;
   } rec_t;

   rec_t        mq[$];
   bit          m_btb_v   [ENTRIES];
   logic [31:0] m_btb_tag [ENTRIES];
   logic [31:0] m_btb_tgt [ENTRIES];
   logic [31:0] m_pc;
   bit          m_fv, m_mis, m_perr;

   task automatic model_reset();
      m_pc = '0; m_fv = 0; m_mis = 0; m_perr = 0;
      mq.delete();
      for (int i = 0; i < ENTRIES; i++) m_btb_v[i] = 0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          rst, stall, pred, rv, rt;
      logic [31:0] tgt;
      logic [31:0] pc;
      bit          fv, fire, pt, mis, perr;
   } vec_t;

   vec_t tbl[$];

   task automatic row(input bit r, input bit s, input bit p, input bit v, input bit t,
                      input logic [31:0] g, input logic [31:0] epc,
                      input bit efv, input bit efire, input bit ept, input bit emis, input bit eperr);
      vec_t e;
      e = '{rst: r, stall: s, pred: p, rv: v, rt: t, tgt: g,
            pc: epc, fv: efv, fire: efire, pt: ept, mis: emis, perr: eperr};
      tbl.push_back(e);
   endtask

   // One clock cycle: drive, check model (and table row if given), advance model.
   task automatic cycle(input bit r, input bit s, input bit p, input bit v, input bit t,
                        input logic [31:0] g, input bit use_tbl, input vec_t e, input int id);
      int          idx;
      bit          hit, e_pt, e_fire, mis;
      logic [31:0] btgt;
      rec_t        h;
      rst = r; stall = s; pred_taken = p; resolve_valid = v; resolve_taken = t; resolve_target = g;
      @(negedge clk);
      idx    = int'(m_pc % ENTRIES);
      hit    = m_btb_v[idx] && (m_btb_tag[idx] == m_pc / ENTRIES);
      btgt   = m_btb_tgt[idx];
      e_pt   = p && hit;
      e_fire = m_fv && !s && (mq.size() < DEPTH);
      check($sformatf("model[%0d].pc", id), pc, m_pc);
      check($sformatf("model[%0d].fetch_valid", id), {31'd0, fetch_valid}, {31'd0, m_fv});
      check($sformatf("model[%0d].fetch_fire", id), {31'd0, fetch_fire}, {31'd0, e_fire});
      check($sformatf("model[%0d].fetch_pred_taken", id), {31'd0, fetch_pred_taken}, {31'd0, e_pt});
      check($sformatf("model[%0d].mispredict", id), {31'd0, mispredict}, {31'd0, m_mis});
      check($sformatf("model[%0d].proto_err", id), {31'd0, proto_err}, {31'd0, m_perr});
      if (use_tbl) begin
         check($sformatf("row%0d.pc", id), pc, e.pc);
         check($sformatf("row%0d.fetch_valid", id), {31'd0, fetch_valid}, {31'd0, e.fv});
         check($sformatf("row%0d.fetch_fire", id), {31'd0, fetch_fire}, {31'd0, e.fire});
         check($sformatf("row%0d.fetch_pred_taken", id), {31'd0, fetch_pred_taken}, {31'd0, e.pt});
         check($sformatf("row%0d.mispredict", id), {31'd0, mispredict}, {31'd0, e.mis});
         check($sformatf("row%0d.proto_err", id), {31'd0, proto_err}, {31'd0, e.perr});
      end
      if (r) begin
         model_reset();
      end else begin
         mis = 0;
         if (v) begin
            if (mq.size() == 0) begin
               m_perr = 1;
            end else begin
               h   = mq.pop_front();
               mis = (h.taken != t) || (t && h.target != g);
               if (t) begin
                  m_btb_v[h.pc % ENTRIES]   = 1;
                  m_btb_tag[h.pc % ENTRIES] = h.pc / ENTRIES;
                  m_btb_tgt[h.pc % ENTRIES] = g;
               end
               if (mis) begin
                  mq.delete();
                  m_pc = t ? g : h.pc + 1;
               end
            end
         end
         if (!mis && e_fire) begin
            mq.push_back('{pc: m_pc, taken: e_pt, target: btgt});
            m_pc = e_pt ? btgt : m_pc + 1;
         end
         m_mis = mis;
         m_fv  = 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t dummy;
      bit   r, s, p, v, t;
      logic [31:0] g;
      dummy = '{default: '0};

      //   rst s p v t tgt      pc     fv fire pt mis perr
      row(1, 0,0,0,0, 32'h0,  32'h0,  0, 0, 0, 0, 0);
      row(0, 0,0,0,0, 32'h0,  32'h0,  0, 0, 0, 0, 0);
      row(0, 0,0,0,0, 32'h0,  32'h0,  1, 1, 0, 0, 0);
      row(0, 0,0,0,0, 32'h0,  32'h1,  1, 1, 0, 0, 0);
      row(0, 0,0,0,0, 32'h0,  32'h2,  1, 1, 0, 0, 0);
      row(0, 0,0,0,0, 32'h0,  32'h3,  1, 1, 0, 0, 0);
      row(0, 0,0,0,0, 32'h0,  32'h4,  1, 0, 0, 0, 0);   // queue full
      row(0, 0,0,0,0, 32'h0,  32'h4,  1, 0, 0, 0, 0);
      row(0, 0,0,1,0, 32'h0,  32'h4,  1, 0, 0, 0, 0);   // pop pc0, still full this cycle
      row(0, 0,0,1,0, 32'h0,  32'h4,  1, 1, 0, 0, 0);   // pop pc1 + push pc4
      row(0, 0,0,1,1, 32'h40, 32'h5,  1, 1, 0, 0, 0);   // pc2 resolves taken: mispredict
      row(0, 0,0,0,0, 32'h0,  32'h40, 1, 1, 0, 1, 0);
      row(0, 0,0,1,1, 32'h2,  32'h41, 1, 1, 0, 0, 0);   // redirect back to pc2
      row(0, 0,1,0,0, 32'h0,  32'h2,  1, 1, 1, 1, 0);   // BTB hit -> predict 0x40
      row(0, 0,0,1,1, 32'h40, 32'h40, 1, 1, 0, 0, 0);   // correct prediction
      row(0, 0,0,1,1, 32'h2,  32'h41, 1, 1, 0, 0, 0);
      row(0, 0,1,0,0, 32'h0,  32'h2,  1, 1, 1, 1, 0);
      row(0, 0,0,1,1, 32'h80, 32'h40, 1, 1, 0, 0, 0);   // target mismatch
      row(0, 0,0,0,0, 32'h0,  32'h80, 1, 1, 0, 1, 0);
      row(0, 0,0,1,1, 32'h2,  32'h81, 1, 1, 0, 0, 0);
      row(0, 0,1,0,0, 32'h0,  32'h2,  1, 1, 1, 1, 0);   // retrained target 0x80
      row(0, 0,0,1,1, 32'h42, 32'h80, 1, 1, 0, 0, 0);
      row(0, 0,1,0,0, 32'h0,  32'h42, 1, 1, 0, 1, 0);   // tag miss -> sequential
      row(0, 0,0,0,0, 32'h0,  32'h43, 1, 1, 0, 0, 0);
      row(0, 1,0,0,0, 32'h0,  32'h44, 1, 0, 0, 0, 0);   // stall
      row(0, 1,0,1,0, 32'h0,  32'h44, 1, 0, 0, 0, 0);   // pop during stall
      row(0, 1,0,0,0, 32'h0,  32'h44, 1, 0, 0, 0, 0);
      row(0, 0,0,1,0, 32'h0,  32'h44, 1, 1, 0, 0, 0);
      row(0, 1,0,1,0, 32'h0,  32'h45, 1, 0, 0, 0, 0);
      row(0, 1,0,1,0, 32'h0,  32'h45, 1, 0, 0, 0, 0);   // resolve on empty queue
      row(0, 1,0,0,0, 32'h0,  32'h45, 1, 0, 0, 0, 1);
      row(0, 0,0,0,0, 32'h0,  32'h45, 1, 1, 0, 0, 1);
      row(1, 0,0,1,1, 32'h99, 32'h46, 1, 1, 0, 0, 1);   // reset beats mispredict
      row(0, 0,0,0,0, 32'h0,  32'h0,  0, 0, 0, 0, 0);
      row(0, 0,0,0,0, 32'h0,  32'h0,  1, 1, 0, 0, 0);

      rst = 1'b1; stall = 0; pred_taken = 0; resolve_valid = 0; resolve_taken = 0; resolve_target = '0;
      model_reset();
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++)
         cycle(tbl[i].rst, tbl[i].stall, tbl[i].pred, tbl[i].rv, tbl[i].rt, tbl[i].tgt, 1'b1, tbl[i], i);

      // Randomized run against the reference model.
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         s = ($urandom_range(0, 3) == 0);
         p = $urandom_range(0, 1) == 1;
         if (mq.size() > 0) v = ($urandom_range(0, 9) < 4);
         else               v = ($urandom_range(0, 99) < 3);
         t = $urandom_range(0, 1) == 1;
         g = 32'($urandom_range(0, 127));
         if (mq.size() > 0 && mq[0].taken && $urandom_range(0, 1) == 1) begin
            t = 1;
            g = mq[0].target;
         end
         cycle(r, s, p, v, t, g, 1'b0, dummy, 1000 + i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
